// File: rtl/fifo_rd_stream_pkg.sv
// Shared async-FIFO definitions for the read-domain stages.
// Buffer depth, default word width and circular index wrap.
package fifo_rd_stream_pkg;

  localparam int D_SIZE_DEF = 8;
  localparam int BUF_DEPTH  = 3;

  typedef logic [1:0] idx_t;

  function automatic idx_t idx_incr(input idx_t i);
    return (i == idx_t'(BUF_DEPTH - 1)) ? '0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read-side and output-stream signal bundle.
// master: the read stage; slave: FIFO core plus consumer.
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
);

  logic              empty;
  logic [D_SIZE-1:0] rd_data;
  logic              r_inc;
  logic              m_valid;
  logic [D_SIZE-1:0] m_data;
  logic              m_ready;
  logic              ovf_err;

  modport master (
    input  empty,
    input  rd_data,
    input  m_ready,
    output r_inc,
    output m_valid,
    output m_data,
    output ovf_err
  );

  modport slave (
    output empty,
    output rd_data,
    output m_ready,
    input  r_inc,
    input  m_valid,
    input  m_data,
    input  ovf_err
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// 3-entry circular buffer behind the RAM read port.
// Tracks occupancy; flags a capture that finds no free slot.
module fifo_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              cap,
  input  logic [D_SIZE-1:0] cap_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [D_SIZE-1:0] m_data,
  output logic [1:0]        occ,
  output logic              ovf_err
);

  logic [D_SIZE-1:0] mem [BUF_DEPTH];
  idx_t              wr_idx;
  idx_t              rd_idx;
  logic              pop;
  logic              wr_en;

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_idx];
  assign pop     = m_valid & m_ready;
  // a full buffer can still take a word if the head leaves this cycle
  assign wr_en   = cap & ((occ != 2'(BUF_DEPTH)) | pop);

  // Storage, indices, occupancy and sticky overflow flag
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_idx  <= '0;
      rd_idx  <= '0;
      occ     <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= cap_data;
        wr_idx      <= idx_incr(wr_idx);
      end
      if (pop) begin
        rd_idx <= idx_incr(rd_idx);
      end
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (cap & ~wr_en) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain output stage: issues FIFO reads and streams words.
// Issue uses only registered state, so m_ready never reaches r_inc.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic             r_clk,
  input  logic             r_rstn,
  fifo_rd_stream_if.master bus
);

  logic       en_q;
  logic       inflight;
  logic [1:0] occ;
  logic [2:0] owed;

  // words already buffered plus the one arriving from RAM
  assign owed = {1'b0, occ} + {2'b00, inflight};

  assign bus.r_inc = en_q & ~bus.empty & (owed < 3'(BUF_DEPTH));

  // Enable after reset release; remember an issued read for one cycle
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      en_q     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      en_q     <= 1'b1;
      inflight <= bus.r_inc;
    end
  end

  fifo_skid_buf #(
    .D_SIZE (D_SIZE)
  ) u_buf (
    .r_clk    (r_clk),
    .r_rstn   (r_rstn),
    .cap      (inflight),
    .cap_data (bus.rd_data),
    .m_ready  (bus.m_ready),
    .m_valid  (bus.m_valid),
    .m_data   (bus.m_data),
    .occ      (occ),
    .ovf_err  (bus.ovf_err)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO/RAM environment, queue model,
// per-cycle compare and directed plus random scenarios.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int DW = 8;

  logic r_clk  = 1'b0;
  logic r_rstn = 1'b0;

  fifo_rd_stream_if #(.D_SIZE(DW)) bus ();

  fifo_rd_stream #(.D_SIZE(DW)) u_dut (
    .r_clk  (r_clk),
    .r_rstn (r_rstn),
    .bus    (bus)
  );

  always #5 r_clk = ~r_clk;

  // FIFO contents: stimulus owns mem/wr_ptr, environment owns rd_ptr
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.empty = (wr_ptr == rd_ptr);

  // model: words owed by RAM (pend) and words held for output (held)
  logic [DW-1:0] held [$];
  logic [DW-1:0] pend [$];
  logic [DW-1:0] got  [$];
  bit m_en   = 1'b0;
  bit in_rst = 1'b1;

  bit            s_inc;
  bit            s_exp_inc;
  bit            s_valid;
  bit            s_ready;
  logic [DW-1:0] s_data;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // per-cycle compare of DUT outputs against the queue model
  initial begin : cmp
    bit ei;
    bit ev;
    forever begin
      @(posedge r_clk);
      #3;
      ei = r_rstn && m_en && (wr_ptr != rd_ptr) &&
           (held.size() + pend.size() < 3);
      ev = (held.size() != 0);
      chk("r_inc", bus.r_inc, ei);
      chk("m_valid", bus.m_valid, ev);
      chk("ovf_err", bus.ovf_err, 0);
      if (ev) chk("m_data", bus.m_data, held[0]);
      if (r_rstn && s_valid && !s_ready) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, s_data);
      end
      s_inc     = bus.r_inc;
      s_exp_inc = ei;
      s_valid   = bus.m_valid;
      s_ready   = bus.m_ready;
      s_data    = bus.m_data;
    end
  end

  // FIFO/RAM environment and model update at each clock edge
  initial begin : env
    forever begin
      @(posedge r_clk or negedge r_rstn);
      if (!r_rstn) begin
        if (!in_rst) rd_ptr <= wr_ptr;
        in_rst = 1'b1;
        held.delete();
        pend.delete();
        m_en = 1'b0;
      end else begin
        in_rst = 1'b0;
        if (s_valid && s_ready) got.push_back(s_data);
        if (held.size() != 0 && s_ready) void'(held.pop_front());
        if (pend.size() != 0) begin
          if (held.size() < 3) held.push_back(pend.pop_front());
          else void'(pend.pop_front());
        end
        if (s_exp_inc) pend.push_back(mem[rd_ptr]);
        if (s_inc && wr_ptr != rd_ptr) begin
          bus.rd_data <= mem[rd_ptr];
          rd_ptr      <= rd_ptr + 1;
        end
        m_en = 1'b1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic drain(input int target, input int budget);
    int n;
    n = 0;
    while (got.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk("drain_count", got.size(), target);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    int cnt;
    int run;
    int maxrun;
    int bad;
    int start;
    int n;

    bus.m_ready = 1'b0;

    // reset with a word waiting in the FIFO
    #12;
    push(8'h11);
    tick();
    #1;
    chk("rst_r_inc", bus.r_inc, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    tick();
    r_rstn = 1'b1;
    #1;
    chk("rel_r_inc_first", bus.r_inc, 0);
    tick();
    #1;
    chk("rel_r_inc_next", bus.r_inc, 1);
    bus.m_ready = 1'b1;
    drain(1, 10);
    chk("rel_word", got[0], 8'h11);
    tick(3);

    // single word latency
    b = got.size();
    push(8'hA5);
    #1;
    chk("single_inc", bus.r_inc, 1);
    tick();
    #1;
    chk("single_v_n1", bus.m_valid, 0);
    tick();
    #1;
    chk("single_v_n2", bus.m_valid, 1);
    chk("single_d_n2", bus.m_data, 8'hA5);
    tick();
    #1;
    chk("single_v_n3", bus.m_valid, 0);
    chk("single_cnt", got.size() - b, 1);
    chk("single_word", got[b], 8'hA5);
    tick(2);

    // streaming 16 words
    b = got.size();
    for (int i = 0; i < 16; i++) push(8'(i));
    cnt = 0;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.r_inc) begin
        cnt++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      tick();
    end
    chk("stream_inc_cnt", cnt, 16);
    chk("stream_inc_run", maxrun, 16);
    drain(b + 16, 40);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (got[b + i] !== 8'(i)) bad++;
    chk("stream_order", bad, 0);

    // back-pressure with 8 words queued
    bus.m_ready = 1'b0;
    b = got.size();
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.r_inc) cnt++;
      tick();
    end
    #1;
    chk("bp_inc_cnt", cnt, 3);
    chk("bp_occ", u_dut.u_buf.occ, 3);
    chk("bp_none_out", got.size() - b, 0);
    tick();
    bus.m_ready = 1'b1;
    tick(8);
    chk("bp_rate", got.size() - b, 8);
    drain(b + 8, 20);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (got[b + i] !== 8'(8'h20 + i)) bad++;
    chk("bp_order", bad, 0);

    // toggled ready over 20 words
    b = got.size();
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    n = 0;
    while (got.size() < b + 20 && n < 80) begin
      bus.m_ready = ~bus.m_ready;
      tick();
      n++;
    end
    bus.m_ready = 1'b1;
    chk("tog_count", got.size() - b, 20);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (got[b + i] !== 8'(8'h40 + i)) bad++;
    chk("tog_order", bad, 0);
    tick(2);

    // reset mid-stream with two held and one in flight
    bus.m_ready = 1'b0;
    b = got.size();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    tick(3);
    #1;
    chk("mid_occ", u_dut.u_buf.occ, 2);
    chk("mid_inflight", u_dut.inflight, 1);
    r_rstn = 1'b0;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_occ", u_dut.u_buf.occ, 0);
    tick();
    r_rstn = 1'b1;
    chk("mid_none_out", got.size() - b, 0);
    push(8'h70);
    push(8'h71);
    bus.m_ready = 1'b1;
    drain(b + 2, 20);
    chk("mid_first_new", got[b], 8'h70);
    chk("mid_second_new", got[b + 1], 8'h71);
    tick(2);

    // random traffic and random back-pressure
    b = got.size();
    start = wr_ptr;
    for (int i = 0; i < 400; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      tick();
    end
    bus.m_ready = 1'b1;
    drain(b + (wr_ptr - start), 200);
    bad = 0;
    for (int i = 0; i < wr_ptr - start; i++)
      if (got[b + i] !== mem[start + i]) bad++;
    chk("rand_order", bad, 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
